irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Interrupt responder for the cpu external interrupt port.
- Collects up to 64 device interrupt sources into a pending register, gates them with a software mask, and drives the cpu irq request line.
- Answers the cpu interrupt-acknowledge cycle by placing the masked pending vector on the data input bus, then clears the delivered bits.
- Sits between the devices/tmemory side and the cpu input mux that selects between RAM data and the interrupt vector.

Parameters:
- NSRC, 64: number of interrupt sources; equals the data bus width; 1..64.
- EDGE_MASK, 64'hFFFF_FFFF_FFFF_FFFF: per source, 1 = rising-edge latched, 0 = level.
- HOLDOFF, 2: cycles o_irq stays low after an acknowledge; 0..15.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-low.
- i_src  in  NSRC  device requests, synchronous to clk.
- i_iack  in  1  interrupt acknowledge from the cpu (cpu o_iack).
- i_wr  in  1  software register write strobe.
- i_waddr  in  2  0 = mask, 1 = set pending (OR), 2 = clear pending (AND-NOT), 3 = ignored.
- i_wdata  in  64  write data; bits above NSRC ignored.
- o_irq  out  1  interrupt request to the cpu (cpu i_irq).
- o_data  out  64  vector on an acknowledge; zero-extended above NSRC.
- o_pending  out  NSRC  raw pending register, for debug/readback.
- o_mask  out  NSRC  mask register.

Behaviour:
- Reset (reset = 0 at a rising clk edge):
  - pending = 0, mask = 0, src_q = 0, state = IDLE, holdoff counter = 0.
  - o_irq = 0; o_data = 0.
- Edge sources: a bit is set in pending when i_src & ~src_q is 1. src_q is i_src registered every cycle.
- Level sources: pending bit is set every cycle i_src is 1. It is never cleared by a source deassert, only by an acknowledge or a software clear. If the source is still high after the clear, the bit is re-set on the next cycle.
- Pending update priority within one cycle, lowest to highest:
  - acknowledge clear;
  - software clear (waddr 2);
  - software set (waddr 1);
  - source set.
  - A new source event in the same cycle as its acknowledge clear is not lost.
- Mask write (waddr 0) takes effect on the next cycle's o_irq evaluation.
- active = pending & mask.
- o_data = (i_iack && state != ACK) ? active : 0. This path is combinational, so the cpu samples the vector in the same cycle it raises o_iack.
- State machine (state and o_irq registered):
  - IDLE: o_irq = 0. Go to REQ when active != 0.
  - REQ: o_irq = 1.
    - When i_iack = 1: snapshot active into ack_vec, clear ack_vec bits from pending per the priority rule, go to ACK.
    - When active becomes 0 (software clear or mask) without an acknowledge: go to IDLE and drop o_irq the next cycle.
  - ACK: o_irq = 0, o_data = 0. Stay while i_iack = 1. When i_iack = 0, load the counter with HOLDOFF and go to HOLDOFF, or go to IDLE if HOLDOFF = 0.
  - HOLDOFF: o_irq = 0. Decrement the counter; at 1, go to IDLE. Pending still accumulates.
- i_iack = 1 in IDLE or HOLDOFF (spurious acknowledge):
  - o_data = active, which may be 0;
  - the same clear and transition to ACK apply;
  - an empty acknowledge is legal and returns 0.
- An acknowledge lasting several cycles delivers the vector only in the first cycle; later cycles return 0 and clear nothing.
- Latency: source event at edge N, with mask set and state IDLE:
  - pending set at N+1;
  - state REQ / o_irq = 1 at N+2.
- Reset asserted mid-acknowledge: everything clears at once and o_irq = 0. The cpu sees a 0 vector if i_iack is still high.

Test Plan:
- Mask = 'hFF, pulse i_src = 'ha5 for 1 cycle, all bits edge -> o_irq rises 2 cycles later. i_iack for 1 cycle -> o_data = 'ha5 that cycle. Pending = 0 after. o_irq low for ACK + HOLDOFF (2) cycles, then stays 0.
- Mask = 'h0F, pulse i_src = 'hF0 -> o_irq stays 0 and o_pending = 'hF0. Write mask 'hFF -> o_irq = 1 two cycles later. Acknowledge returns 'hF0.
- EDGE_MASK bit 3 = 0 (level), hold i_src[3] = 1, mask = 'h8. Acknowledge returns 'h8 -> pending bit 3 re-sets next cycle and o_irq re-asserts right after HOLDOFF expires.
- In REQ with pending = 'h1, pulse i_src[1] in the exact acknowledge cycle -> o_data = 'h1 and pending = 'h2 afterwards. Second acknowledge returns 'h2.
- i_iack held 4 cycles -> o_data = vector on cycle 1 only, 0 on cycles 2-4. No double clear. HOLDOFF starts after i_iack falls.
- Set pending 'h3 via waddr 1, then clear via waddr 2 while in REQ -> o_irq drops one cycle later and state returns to IDLE. Assert reset low during ACK -> o_irq = 0, o_pending = 0, o_mask = 0 next edge.

Source files
------------

// File: rtl/irq_controller.sv
// irq_controller: collects device interrupt sources into a pending register,
// masks them, raises the cpu irq line and answers the acknowledge cycle with
// the masked pending vector, clearing the bits it delivered.
module irq_controller #(
  parameter int          NSRC      = 64,
  parameter logic [63:0] EDGE_MASK = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter int          HOLDOFF   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] i_src,
  input  logic            i_iack,
  input  logic            i_wr,
  input  logic [1:0]      i_waddr,
  input  logic [63:0]     i_wdata,
  output logic            o_irq,
  output logic [63:0]     o_data,
  output logic [NSRC-1:0] o_pending,
  output logic [NSRC-1:0] o_mask
);

  typedef enum logic [1:0] {IDLE, REQ, ACK, HOLD} state_t;

  localparam logic [NSRC-1:0] EDGE_SEL  = EDGE_MASK[NSRC-1:0];
  localparam logic [3:0]      HOLD_LOAD = 4'(HOLDOFF);

  state_t          state;
  logic [3:0]      cnt;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] active;
  logic [NSRC-1:0] wdata_n;
  logic [NSRC-1:0] src_set;
  logic [NSRC-1:0] ack_clr;
  logic [NSRC-1:0] pending_next;
  logic            take;

  // Pending update: ack clear, then software clear, software set, and source
  // set last so that a source event coinciding with its own clear survives.
  always_comb begin
    active  = pending & mask;
    wdata_n = i_wdata[NSRC-1:0];
    // Only the first cycle of an acknowledge delivers and clears.
    take    = i_iack && (state != ACK);
    ack_clr = take ? active : '0;
    src_set = (i_src & ~src_q & EDGE_SEL) | (i_src & ~EDGE_SEL);
    pending_next = pending & ~ack_clr;
    if (i_wr && i_waddr == 2'd2) pending_next = pending_next & ~wdata_n;
    if (i_wr && i_waddr == 2'd1) pending_next = pending_next | wdata_n;
    pending_next = pending_next | src_set;
    // Combinational so the cpu can sample the vector in its iack cycle.
    o_data = '0;
    o_data[NSRC-1:0] = ack_clr;
  end

  // Registers and the request/acknowledge/holdoff state machine.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pending <= '0;
      mask    <= '0;
      src_q   <= '0;
      state   <= IDLE;
      cnt     <= '0;
      o_irq   <= 1'b0;
    end else begin
      src_q   <= i_src;
      pending <= pending_next;
      if (i_wr && i_waddr == 2'd0) mask <= wdata_n;
      case (state)
        IDLE: begin
          if (i_iack) begin
            state <= ACK;
            o_irq <= 1'b0;
          end else if (|active) begin
            state <= REQ;
            o_irq <= 1'b1;
          end
        end
        REQ: begin
          if (i_iack) begin
            state <= ACK;
            o_irq <= 1'b0;
          end else if (active == '0) begin
            state <= IDLE;
            o_irq <= 1'b0;
          end
        end
        ACK: begin
          o_irq <= 1'b0;
          if (!i_iack) begin
            if (HOLD_LOAD == 4'd0) begin
              state <= IDLE;
            end else begin
              cnt   <= HOLD_LOAD;
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          o_irq <= 1'b0;
          if (i_iack) begin
            state <= ACK;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt <= 4'd1) state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          o_irq <= 1'b0;
        end
      endcase
    end
  end

  assign o_pending = pending;
  assign o_mask    = mask;

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: randomized and directed stimulus for irq_controller,
// checked against a behavioural model of the interrupt rules.
module tb_irq_controller;

  localparam int          NSRC    = 16;
  localparam logic [63:0] EDGE    = 64'hFFFF_FFFF_FFFF_FFF7;
  localparam logic [15:0] EDGE16  = 16'hFFF7;
  localparam int          HOLDOFF = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] src;
  logic        iack, wr;
  logic [1:0]  waddr;
  logic [63:0] wdata;
  logic        irq;
  logic [63:0] data;
  logic [15:0] pending, mask;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [15:0] m_pend, m_mask, m_prev;
  logic        m_irq;
  bit          m_in_ack;
  int          m_hold;
  logic [63:0] exp_data, obs_data;

  irq_controller #(.NSRC(NSRC), .EDGE_MASK(EDGE), .HOLDOFF(HOLDOFF)) dut (
    .clk(clk), .reset(reset), .i_src(src), .i_iack(iack), .i_wr(wr),
    .i_waddr(waddr), .i_wdata(wdata), .o_irq(irq), .o_data(data),
    .o_pending(pending), .o_mask(mask)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [15:0] s, input logic a, input logic w,
                       input logic [1:0] ad, input logic [63:0] wd);
    src = s; iack = a; wr = w; waddr = ad; wdata = wd;
  endtask

  // One clock: sample o_data mid-cycle, advance DUT and model together.
  task automatic cyc();
    logic [15:0] act, ev, np, nm;
    bit          deliver, nin;
    logic        nirq;
    int          nh;
    @(negedge clk);
    obs_data = data;
    act      = m_pend & m_mask;
    deliver  = iack && !m_in_ack;
    exp_data = deliver ? {48'h0, act} : 64'h0;
    // Edge sources fire on a 0->1 change, level sources whenever high.
    ev = (src & ~m_prev & EDGE16) | (src & ~EDGE16);
    np = deliver ? (m_pend & ~act) : m_pend;
    if (wr && waddr == 2'd2) np = np & ~wdata[15:0];
    if (wr && waddr == 2'd1) np = np | wdata[15:0];
    np = np | ev;
    nm = (wr && waddr == 2'd0) ? wdata[15:0] : m_mask;
    nin = m_in_ack; nh = m_hold; nirq = m_irq;
    if (deliver) begin
      nin = 1; nirq = 1'b0; nh = 0;
    end else if (m_in_ack) begin
      nirq = 1'b0;
      if (!iack) begin nin = 0; nh = HOLDOFF; end
    end else if (m_hold > 0) begin
      nh = m_hold - 1; nirq = 1'b0;
    end else begin
      nirq = (act != 16'h0);
    end
    @(posedge clk);
    #1;
    if (!reset) begin
      m_pend = 0; m_mask = 0; m_prev = 0; m_irq = 0; m_in_ack = 0; m_hold = 0;
    end else begin
      m_pend = np; m_mask = nm; m_prev = src; m_irq = nirq; m_in_ack = nin; m_hold = nh;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; drive(0, 0, 0, 0, 0); cyc(); reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; drive(16'hFFFF, 1, 1, 2'd0, '1);
    cyc(); cyc();
    checks++;
    if ({irq, pending, mask} !== 33'h0) begin
      errors++; $display("FAIL reset_regs got irq=%b pend=%h mask=%h want 0 0 0", irq, pending, mask);
    end
    checks++;
    if (obs_data !== 64'h0) begin
      errors++; $display("FAIL reset_data got %h want 0", obs_data);
    end
    reset = 1'b1; drive(0, 0, 0, 0, 0); cyc();
    checks++;
    if ({irq, pending, mask} !== {m_irq, m_pend, m_mask}) begin
      errors++; $display("FAIL reset_release got %b/%h/%h want %b/%h/%h", irq, pending, mask, m_irq, m_pend, m_mask);
    end
  endtask

  task automatic test_basic();
    int lows;
    do_reset();
    drive(0, 0, 1, 2'd0, 64'hFF); cyc();
    drive(16'hA5, 0, 0, 0, 0); cyc();
    drive(0, 0, 0, 0, 0);
    checks++;
    if (irq !== 1'b0 || pending !== 16'hA5) begin
      errors++; $display("FAIL basic_pend got irq=%b pend=%h want 0 a5", irq, pending);
    end
    cyc();
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL basic_irq_rise got %b want 1", irq);
    end
    drive(0, 1, 0, 0, 0); cyc();
    checks++;
    if (obs_data !== 64'hA5 || pending !== 16'h0 || irq !== 1'b0) begin
      errors++; $display("FAIL basic_ack got data=%h pend=%h irq=%b want a5 0 0", obs_data, pending, irq);
    end
    drive(0, 0, 0, 0, 0);
    lows = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (irq === 1'b0) lows++;
      checks++;
      if ({irq, pending, obs_data} !== {m_irq, m_pend, exp_data}) begin
        errors++; $display("FAIL basic_after[%0d] got %b/%h/%h want %b/%h/%h", i, irq, pending, obs_data, m_irq, m_pend, exp_data);
      end
    end
    checks++;
    if (lows !== 6) begin
      errors++; $display("FAIL basic_stays_low got %0d low cycles want 6", lows);
    end
  endtask

  task automatic test_mask();
    do_reset();
    drive(0, 0, 1, 2'd0, 64'h0F); cyc();
    drive(16'hF0, 0, 0, 0, 0); cyc();
    drive(0, 0, 0, 0, 0); cyc(); cyc(); cyc();
    checks++;
    if (irq !== 1'b0 || pending !== 16'hF0) begin
      errors++; $display("FAIL mask_blocked got irq=%b pend=%h want 0 f0", irq, pending);
    end
    drive(0, 0, 1, 2'd0, 64'hFF); cyc();
    drive(0, 0, 0, 0, 0); cyc();
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL mask_open got irq=%b want 1", irq);
    end
    drive(0, 1, 0, 0, 0); cyc();
    checks++;
    if (obs_data !== 64'hF0) begin
      errors++; $display("FAIL mask_vector got %h want f0", obs_data);
    end
    drive(0, 0, 0, 0, 0); cyc();
  endtask

  task automatic test_level();
    int rise;
    do_reset();
    drive(0, 0, 1, 2'd0, 64'h8); cyc();
    drive(16'h8, 0, 0, 0, 0); cyc(); cyc();
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL level_irq got %b want 1", irq);
    end
    drive(16'h8, 1, 0, 0, 0); cyc();
    checks++;
    if (obs_data !== 64'h8 || pending !== 16'h8) begin
      errors++; $display("FAIL level_ack got data=%h pend=%h want 8 8", obs_data, pending);
    end
    drive(16'h8, 0, 0, 0, 0);
    rise = -1;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      if (rise < 0 && irq === 1'b1) rise = i;
      checks++;
      if ({irq, pending} !== {m_irq, m_pend}) begin
        errors++; $display("FAIL level_cycle[%0d] got %b/%h want %b/%h", i, irq, pending, m_irq, m_pend);
      end
    end
    checks++;
    if (rise !== HOLDOFF + 2) begin
      errors++; $display("FAIL level_reassert got cycle %0d want %0d", rise, HOLDOFF + 2);
    end
  endtask

  task automatic test_same_cycle();
    int n;
    do_reset();
    drive(0, 0, 1, 2'd0, 64'hFF); cyc();
    drive(16'h1, 0, 0, 0, 0); cyc();
    drive(0, 0, 0, 0, 0); cyc();
    drive(16'h2, 1, 0, 0, 0); cyc();
    checks++;
    if (obs_data !== 64'h1 || pending !== 16'h2) begin
      errors++; $display("FAIL same_cycle got data=%h pend=%h want 1 2", obs_data, pending);
    end
    drive(0, 0, 0, 0, 0);
    n = 0;
    while (irq !== 1'b1 && n < 12) begin cyc(); n++; end
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL same_cycle_rearm got irq=%b want 1 within 12 cycles", irq);
    end
    drive(0, 1, 0, 0, 0); cyc();
    checks++;
    if (obs_data !== 64'h2) begin
      errors++; $display("FAIL same_cycle_second got %h want 2", obs_data);
    end
    drive(0, 0, 0, 0, 0); cyc();
  endtask

  task automatic test_long_ack();
    int rise;
    do_reset();
    drive(0, 0, 1, 2'd0, 64'hFF); cyc();
    drive(16'h30, 0, 0, 0, 0); cyc();
    drive(0, 0, 0, 0, 0); cyc();
    for (int i = 0; i < 4; i++) begin
      drive((i == 1) ? 16'h1 : 16'h0, 1, 0, 0, 0);
      cyc();
      checks++;
      if (obs_data !== ((i == 0) ? 64'h30 : 64'h0) || irq !== 1'b0) begin
        errors++; $display("FAIL long_ack[%0d] got data=%h irq=%b want %h 0", i, obs_data, irq, (i == 0) ? 64'h30 : 64'h0);
      end
    end
    checks++;
    if (pending !== 16'h1) begin
      errors++; $display("FAIL long_ack_no_double_clear got pend=%h want 1", pending);
    end
    drive(0, 0, 0, 0, 0);
    rise = -1;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      if (rise < 0 && irq === 1'b1) rise = i;
    end
    checks++;
    if (rise !== HOLDOFF + 2) begin
      errors++; $display("FAIL long_ack_holdoff got cycle %0d want %0d", rise, HOLDOFF + 2);
    end
  endtask

  task automatic test_sw_and_reset();
    do_reset();
    drive(0, 0, 1, 2'd0, 64'hFF); cyc();
    drive(0, 0, 1, 2'd1, 64'h3); cyc();
    drive(0, 0, 0, 0, 0); cyc();
    checks++;
    if (irq !== 1'b1 || pending !== 16'h3) begin
      errors++; $display("FAIL sw_set got irq=%b pend=%h want 1 3", irq, pending);
    end
    drive(0, 0, 1, 2'd2, 64'h3); cyc();
    checks++;
    if (irq !== 1'b1 || pending !== 16'h0) begin
      errors++; $display("FAIL sw_clear got irq=%b pend=%h want 1 0", irq, pending);
    end
    drive(0, 0, 0, 0, 0); cyc();
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL sw_clear_drop got irq=%b want 0", irq);
    end
    drive(0, 0, 1, 2'd1, 64'h3); cyc();
    drive(0, 0, 0, 0, 0); cyc();
    drive(0, 1, 0, 0, 0); cyc();
    reset = 1'b0; cyc();
    checks++;
    if ({irq, pending, mask} !== 33'h0) begin
      errors++; $display("FAIL reset_in_ack got %b/%h/%h want 0/0/0", irq, pending, mask);
    end
    reset = 1'b1; cyc();
    checks++;
    if (obs_data !== 64'h0) begin
      errors++; $display("FAIL reset_in_ack_data got %h want 0", obs_data);
    end
    drive(0, 0, 0, 0, 0); cyc();
  endtask

  task automatic test_random();
    logic [15:0] s;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      s = (($urandom % 4) == 0) ? 16'($urandom) : 16'h0;
      drive(s, ($urandom % 6) == 0, ($urandom % 8) == 0, 2'($urandom), {$urandom, $urandom});
      reset = (($urandom % 400) == 0) ? 1'b0 : 1'b1;
      cyc();
      checks++;
      if ({irq, pending, mask, obs_data} !== {m_irq, m_pend, m_mask, exp_data}) begin
        errors++;
        $display("FAIL random[%0d] got irq=%b pend=%h mask=%h data=%h want irq=%b pend=%h mask=%h data=%h",
                 i, irq, pending, mask, obs_data, m_irq, m_pend, m_mask, exp_data);
      end
    end
    reset = 1'b1;
  endtask

  initial begin
    m_pend = 0; m_mask = 0; m_prev = 0; m_irq = 0; m_in_ack = 0; m_hold = 0;
    exp_data = 0; obs_data = 0;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    test_reset();
    test_basic();
    test_mask();
    test_level();
    test_same_cycle();
    test_long_ack();
    test_sw_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
